ball_motion: RTL and testbench
==============================

Name: ball_motion

Overview:
- Consumes the 30 Hz single-cycle frame-rate enable pulse from the clock divider. Advances a square ball sprite's top-left position across the visible VGA area on each pulse.
- On each pulse the ball moves diagonally by a fixed step. It reflects off the four screen edges.
- Outputs feed the pixel renderer (x/y/size compare) and a score/sound stage (bounce pulse and counter).

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- BALL_SIZE, 16, ball edge length in pixels.
- STEP, 4, pixels moved per axis per tick.
- X_INIT, 312, reset x position; legal range 0..H_ACTIVE-BALL_SIZE.
- Y_INIT, 232, reset y position; legal range 0..V_ACTIVE-BALL_SIZE.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  single-cycle advance pulse from the clock divider.
- enable  input  1  motion enable; when low, ticks are ignored.
- ballX  output  10  ball left edge, pixels.
- ballY  output  10  ball top edge, lines.
- dirX  output  1  1 = moving right, 0 = moving left.
- dirY  output  1  1 = moving down, 0 = moving up.
- bouncePulse  output  1  one-cycle pulse after a move that hit any edge.
- bounceCount  output  8  saturating count of axis bounces.

Behaviour:
- One clock. Reset is synchronous and active-high. All state updates on posedge clk.
- Reset values:
  - ballX=X_INIT, ballY=Y_INIT
  - dirX=1, dirY=1
  - bouncePulse=0, bounceCount=0
  - FSM=WAIT
- Reset mid-operation aborts any move and restores these values on the next edge.
- FSM states: WAIT, MOVE_X, MOVE_Y, REPORT.
  - WAIT: if tick && enable -> MOVE_X; otherwise stay.
  - MOVE_X: update ballX/dirX -> MOVE_Y.
  - MOVE_Y: update ballY/dirY -> REPORT.
  - REPORT: bouncePulse=1 for this cycle only if either axis bounced during this move -> WAIT.
- Latency: for a tick sampled in WAIT in cycle N:
  - new ballX is visible in N+2
  - new ballY is visible in N+3
  - bouncePulse is high in N+3 only.
- A tick arriving in any state other than WAIT is dropped, not queued.
- X rule (11-bit arithmetic, no wrap). XMAX = H_ACTIVE-BALL_SIZE.
  - Moving right: if ballX+STEP >= XMAX then ballX=XMAX, dirX=0, bounce; else ballX+=STEP.
  - Moving left: if ballX <= STEP then ballX=0, dirX=1, bounce; else ballX-=STEP.
- Y rule: identical with YMAX = V_ACTIVE-BALL_SIZE, using ballY and dirY.
- bounceCount:
  - +1 per axis bounce, so a corner hit adds 2.
  - Saturates at 255; never wraps.
  - Cleared only by reset.
- Position is always clamped to [0, MAX]; the ball never leaves the visible area.
- Landing exactly on a limit counts as a bounce.
- enable low in WAIT: all outputs hold. enable changing mid-move does not abort the move.
- bouncePulse is low in every state except REPORT.

Optional Feature:
- Macro: BALL_PAUSE_EN.
- Defined:
  - Adds input port pause (1 bit) and an internal paused flag, reset 0.
  - A rising edge on pause (registered previous-value detect) toggles paused.
  - While paused=1, WAIT ignores tick exactly as if enable were low.
  - A pause edge during MOVE_X/MOVE_Y/REPORT still toggles the flag but does not abort the move.
- Undefined: no pause port, no flag; behaviour is exactly as above.

Test Plan:
- Reset, then one tick in cycle N -> ballX=316 at N+2, ballY=236 at N+3, bouncePulse never high, bounceCount=0.
- X_INIT=622, one tick -> ballX=624, dirX=0, bouncePulse high in N+3 only, bounceCount=1. Next tick -> ballX=620.
- X_INIT=622, Y_INIT=462, one tick -> ballX=624, ballY=464, dirX=0, dirY=0, single bouncePulse, bounceCount=2.
- enable=0 with 10 ticks -> all outputs unchanged. Then a tick in MOVE_X (two ticks 1 cycle apart) -> exactly one step taken.
- Drive ~130 corner-alternating bounces (or force long run) -> bounceCount stops at 255; assert reset mid-MOVE_Y -> next cycle ballX=X_INIT, ballY=Y_INIT, count=0, FSM=WAIT.
- BALL_PAUSE_EN defined: pulse pause, 5 ticks -> no motion; pulse pause again, 1 tick -> ballX advances by 4.

Source files
------------

// File: rtl/ball_motion_if.sv
// Bus between the frame-tick source and the ball motion engine.
// The optional pause input appears only when BALL_PAUSE_EN is defined.
interface ball_motion_if;
    logic       tick;
    logic       enable;
`ifdef BALL_PAUSE_EN
    logic       pause;
`endif
    logic [9:0] ballX;
    logic [9:0] ballY;
    logic       dirX;
    logic       dirY;
    logic       bouncePulse;
    logic [7:0] bounceCount;
    logic [1:0] state;

    // tick/enable are level inputs sampled on posedge clk; tick is honoured only
    // while state is WAIT, otherwise it is dropped (no valid/ready backpressure).
`ifdef BALL_PAUSE_EN
    modport master (output tick, enable, pause,
                    input  ballX, ballY, dirX, dirY, bouncePulse, bounceCount, state);
    modport slave  (input  tick, enable, pause,
                    output ballX, ballY, dirX, dirY, bouncePulse, bounceCount, state);
`else
    modport master (output tick, enable,
                    input  ballX, ballY, dirX, dirY, bouncePulse, bounceCount, state);
    modport slave  (input  tick, enable,
                    output ballX, ballY, dirX, dirY, bouncePulse, bounceCount, state);
`endif
endinterface

// File: rtl/ball_motion.sv
// Bouncing ball position engine: one diagonal step per accepted tick, X then Y.
// Optional pause toggle input is compiled in with BALL_PAUSE_EN.
module ball_motion #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int BALL_SIZE = 16,
    parameter int STEP      = 4,
    parameter int X_INIT    = 312,
    parameter int Y_INIT    = 232
) (
    input logic          clk,
    input logic          reset,
    ball_motion_if.slave bus
);
    typedef enum logic [1:0] {S_WAIT = 2'd0, S_MOVE_X = 2'd1, S_MOVE_Y = 2'd2, S_REPORT = 2'd3} state_t;

    localparam logic [10:0] XMAX_W = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic [10:0] YMAX_W = 11'(V_ACTIVE - BALL_SIZE);
    localparam logic [10:0] STEP_W = 11'(STEP);

    state_t     state_q, state_d;
    logic [9:0] x_q, y_q, x_next, y_next;
    logic       dir_x_q, dir_y_q, dir_x_next, dir_y_next;
    logic       hit_x, hit_y;
    logic       bounce_x_q, bounce_y_q;
    logic [7:0] count_q, count_inc;
    logic [10:0] x_sum, y_sum;
    logic       go;

`ifdef BALL_PAUSE_EN
    logic pause_q, paused_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            pause_q  <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            pause_q <= bus.pause;
            if (bus.pause && !pause_q) paused_q <= !paused_q;
        end
    end
    assign go = bus.tick && bus.enable && !paused_q;
`else
    assign go = bus.tick && bus.enable;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_WAIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT:   if (go) state_d = S_MOVE_X;
            S_MOVE_X: state_d = S_MOVE_Y;
            S_MOVE_Y: state_d = S_REPORT;
            S_REPORT: state_d = S_WAIT;
            default:  state_d = S_WAIT;
        endcase
    end

    // 11-bit sums so a step past the right/bottom limit cannot wrap before the compare.
    always_comb begin
        x_sum      = {1'b0, x_q} + STEP_W;
        y_sum      = {1'b0, y_q} + STEP_W;
        x_next     = x_q;
        y_next     = y_q;
        dir_x_next = dir_x_q;
        dir_y_next = dir_y_q;
        hit_x      = 1'b0;
        hit_y      = 1'b0;
        if (dir_x_q) begin
            if (x_sum >= XMAX_W) begin
                x_next = XMAX_W[9:0]; dir_x_next = 1'b0; hit_x = 1'b1;
            end else x_next = x_sum[9:0];
        end else begin
            if ({1'b0, x_q} <= STEP_W) begin
                x_next = 10'd0; dir_x_next = 1'b1; hit_x = 1'b1;
            end else x_next = x_q - STEP_W[9:0];
        end
        if (dir_y_q) begin
            if (y_sum >= YMAX_W) begin
                y_next = YMAX_W[9:0]; dir_y_next = 1'b0; hit_y = 1'b1;
            end else y_next = y_sum[9:0];
        end else begin
            if ({1'b0, y_q} <= STEP_W) begin
                y_next = 10'd0; dir_y_next = 1'b1; hit_y = 1'b1;
            end else y_next = y_q - STEP_W[9:0];
        end
        count_inc = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q        <= 10'(X_INIT);
            y_q        <= 10'(Y_INIT);
            dir_x_q    <= 1'b1;
            dir_y_q    <= 1'b1;
            bounce_x_q <= 1'b0;
            bounce_y_q <= 1'b0;
            count_q    <= 8'd0;
        end else begin
            case (state_q)
                S_WAIT: if (go) begin
                    bounce_x_q <= 1'b0;
                    bounce_y_q <= 1'b0;
                end
                S_MOVE_X: begin
                    x_q        <= x_next;
                    dir_x_q    <= dir_x_next;
                    bounce_x_q <= hit_x;
                    if (hit_x) count_q <= count_inc;
                end
                S_MOVE_Y: begin
                    y_q        <= y_next;
                    dir_y_q    <= dir_y_next;
                    bounce_y_q <= hit_y;
                    if (hit_y) count_q <= count_inc;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.ballX       = x_q;
        bus.ballY       = y_q;
        bus.dirX        = dir_x_q;
        bus.dirY        = dir_y_q;
        bus.bounceCount = count_q;
        bus.state       = state_q;
        bus.bouncePulse = (state_q == S_REPORT) && (bounce_x_q || bounce_y_q);
    end
endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: four instances with different start points/geometry.
// Define BALL_PAUSE_EN to include the pause scenario.
module tb_ball_motion;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick = 1'b0;
    logic enable = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ball_motion_if if_a ();
    ball_motion_if if_b ();
    ball_motion_if if_c ();
    ball_motion_if if_d ();

    assign if_a.tick = tick;  assign if_a.enable = enable;
    assign if_b.tick = tick;  assign if_b.enable = enable;
    assign if_c.tick = tick;  assign if_c.enable = enable;
    assign if_d.tick = tick;  assign if_d.enable = enable;
`ifdef BALL_PAUSE_EN
    logic pause = 1'b0;
    assign if_a.pause = pause;
    assign if_b.pause = pause;
    assign if_c.pause = pause;
    assign if_d.pause = pause;
`endif

    ball_motion dut_a (.clk(clk), .reset(reset), .bus(if_a));
    ball_motion #(.X_INIT(622)) dut_b (.clk(clk), .reset(reset), .bus(if_b));
    ball_motion #(.X_INIT(622), .Y_INIT(462)) dut_c (.clk(clk), .reset(reset), .bus(if_c));
    // Tiny field: XMAX = YMAX = 4 = STEP, so every move is a corner bounce.
    ball_motion #(.H_ACTIVE(20), .V_ACTIVE(20), .X_INIT(0), .Y_INIT(0)) dut_d (.clk(clk), .reset(reset), .bus(if_d));

    // Full accepted move: tick for one cycle, then return at the negedge after REPORT.
    task automatic send_move();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({if_a.ballX, if_a.ballY, if_a.dirX, if_a.dirY, if_a.bouncePulse, if_a.bounceCount, if_a.state}
            !== {10'd312, 10'd232, 1'b1, 1'b1, 1'b0, 8'd0, 2'd0}) begin
            errors++;
            $display("FAIL reset_a: x=%0d y=%0d dx=%0b dy=%0b p=%0b c=%0d s=%0d required 312 232 1 1 0 0 0",
                     if_a.ballX, if_a.ballY, if_a.dirX, if_a.dirY, if_a.bouncePulse, if_a.bounceCount, if_a.state);
        end
        checks++;
        if ({if_c.ballX, if_c.ballY} !== {10'd622, 10'd462}) begin
            errors++;
            $display("FAIL reset_c: x=%0d y=%0d required 622 462", if_c.ballX, if_c.ballY);
        end
    endtask

    task automatic test_single_tick();
        @(negedge clk) tick = 1'b1;          // cycle N
        @(negedge clk) tick = 1'b0;          // N+1
        checks++;
        if ({if_a.state, if_a.ballX} !== {2'd1, 10'd312}) begin
            errors++;
            $display("FAIL n1_a: state=%0d x=%0d required 1 312", if_a.state, if_a.ballX);
        end
        @(negedge clk);                      // N+2
        checks++;
        if ({if_a.ballX, if_a.ballY, if_a.bouncePulse} !== {10'd316, 10'd232, 1'b0}) begin
            errors++;
            $display("FAIL n2_a: x=%0d y=%0d p=%0b required 316 232 0", if_a.ballX, if_a.ballY, if_a.bouncePulse);
        end
        checks++;
        if ({if_b.ballX, if_b.dirX, if_b.bouncePulse} !== {10'd624, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL n2_b: x=%0d dx=%0b p=%0b required 624 0 0", if_b.ballX, if_b.dirX, if_b.bouncePulse);
        end
        @(negedge clk);                      // N+3
        checks++;
        if ({if_a.ballY, if_a.bouncePulse, if_a.bounceCount} !== {10'd236, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL n3_a: y=%0d p=%0b c=%0d required 236 0 0", if_a.ballY, if_a.bouncePulse, if_a.bounceCount);
        end
        checks++;
        if ({if_b.ballY, if_b.bouncePulse, if_b.bounceCount} !== {10'd236, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL n3_b: y=%0d p=%0b c=%0d required 236 1 1", if_b.ballY, if_b.bouncePulse, if_b.bounceCount);
        end
        checks++;
        if ({if_c.ballX, if_c.ballY, if_c.dirX, if_c.dirY, if_c.bouncePulse, if_c.bounceCount}
            !== {10'd624, 10'd464, 1'b0, 1'b0, 1'b1, 8'd2}) begin
            errors++;
            $display("FAIL n3_c: x=%0d y=%0d dx=%0b dy=%0b p=%0b c=%0d required 624 464 0 0 1 2",
                     if_c.ballX, if_c.ballY, if_c.dirX, if_c.dirY, if_c.bouncePulse, if_c.bounceCount);
        end
        @(negedge clk);                      // N+4
        checks++;
        if ({if_b.bouncePulse, if_c.bouncePulse, if_a.state} !== {1'b0, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL n4_pulse_low: pb=%0b pc=%0b state=%0d required 0 0 0",
                     if_b.bouncePulse, if_c.bouncePulse, if_a.state);
        end
        checks++;
        if ({if_d.ballX, if_d.ballY, if_d.bounceCount} !== {10'd4, 10'd4, 8'd2}) begin
            errors++;
            $display("FAIL tiny_first: x=%0d y=%0d c=%0d required 4 4 2", if_d.ballX, if_d.ballY, if_d.bounceCount);
        end
    endtask

    task automatic test_second_tick();
        send_move();
        checks++;
        if ({if_b.ballX, if_b.bounceCount} !== {10'd620, 8'd1}) begin
            errors++;
            $display("FAIL second_b: x=%0d c=%0d required 620 1", if_b.ballX, if_b.bounceCount);
        end
        checks++;
        if ({if_c.ballX, if_c.ballY, if_c.bounceCount} !== {10'd620, 10'd460, 8'd2}) begin
            errors++;
            $display("FAIL second_c: x=%0d y=%0d c=%0d required 620 460 2", if_c.ballX, if_c.ballY, if_c.bounceCount);
        end
        checks++;
        if ({if_a.ballX, if_a.ballY} !== {10'd320, 10'd240}) begin
            errors++;
            $display("FAIL second_a: x=%0d y=%0d required 320 240", if_a.ballX, if_a.ballY);
        end
    endtask

    task automatic test_enable_and_drop();
        enable = 1'b0;
        for (int i = 0; i < 10; i++) send_move();
        checks++;
        if ({if_a.ballX, if_a.ballY, if_a.dirX, if_a.dirY, if_a.bounceCount, if_a.state}
            !== {10'd320, 10'd240, 1'b1, 1'b1, 8'd0, 2'd0}) begin
            errors++;
            $display("FAIL enable_low_hold: x=%0d y=%0d c=%0d s=%0d required 320 240 0 0",
                     if_a.ballX, if_a.ballY, if_a.bounceCount, if_a.state);
        end
        enable = 1'b1;
        // Tick held through MOVE_X, MOVE_Y and REPORT: only the WAIT sample counts.
        @(negedge clk) tick = 1'b1;
        repeat (4) @(negedge clk);
        tick = 1'b0;
        checks++;
        if ({if_a.ballX, if_a.ballY, if_a.state} !== {10'd324, 10'd244, 2'd0}) begin
            errors++;
            $display("FAIL drop_busy_ticks: x=%0d y=%0d s=%0d required 324 244 0", if_a.ballX, if_a.ballY, if_a.state);
        end
        checks++;
        if ({if_d.ballX, if_d.ballY, if_d.bounceCount} !== {10'd4, 10'd4, 8'd6}) begin
            errors++;
            $display("FAIL drop_tiny: x=%0d y=%0d c=%0d required 4 4 6", if_d.ballX, if_d.ballY, if_d.bounceCount);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 124; i++) send_move();
        checks++;
        if ({if_d.ballX, if_d.ballY, if_d.bounceCount} !== {10'd4, 10'd4, 8'd254}) begin
            errors++;
            $display("FAIL sat_254: x=%0d y=%0d c=%0d required 4 4 254", if_d.ballX, if_d.ballY, if_d.bounceCount);
        end
        send_move();
        checks++;
        if ({if_d.ballX, if_d.ballY, if_d.bounceCount} !== {10'd0, 10'd0, 8'd255}) begin
            errors++;
            $display("FAIL sat_255: x=%0d y=%0d c=%0d required 0 0 255", if_d.ballX, if_d.ballY, if_d.bounceCount);
        end
        send_move();
        checks++;
        if ({if_d.ballX, if_d.bounceCount} !== {10'd4, 8'd255}) begin
            errors++;
            $display("FAIL sat_hold: x=%0d c=%0d required 4 255", if_d.ballX, if_d.bounceCount);
        end
    endtask

    task automatic test_reset_mid_move();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        @(negedge clk);
        checks++;
        if (if_a.state !== 2'd2) begin
            errors++;
            $display("FAIL mid_state: state=%0d required 2", if_a.state);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({if_a.ballX, if_a.ballY, if_a.dirX, if_a.dirY, if_a.bouncePulse, if_a.bounceCount, if_a.state}
            !== {10'd312, 10'd232, 1'b1, 1'b1, 1'b0, 8'd0, 2'd0}) begin
            errors++;
            $display("FAIL mid_reset_a: x=%0d y=%0d p=%0b c=%0d s=%0d required 312 232 0 0 0",
                     if_a.ballX, if_a.ballY, if_a.bouncePulse, if_a.bounceCount, if_a.state);
        end
        checks++;
        if ({if_d.ballX, if_d.ballY, if_d.bounceCount} !== {10'd0, 10'd0, 8'd0}) begin
            errors++;
            $display("FAIL mid_reset_d: x=%0d y=%0d c=%0d required 0 0 0", if_d.ballX, if_d.ballY, if_d.bounceCount);
        end
    endtask

`ifdef BALL_PAUSE_EN
    task automatic test_pause();
        @(negedge clk) pause = 1'b1;
        @(negedge clk) pause = 1'b0;
        for (int i = 0; i < 5; i++) send_move();
        checks++;
        if ({if_a.ballX, if_a.ballY, if_a.state} !== {10'd312, 10'd232, 2'd0}) begin
            errors++;
            $display("FAIL paused_hold: x=%0d y=%0d s=%0d required 312 232 0", if_a.ballX, if_a.ballY, if_a.state);
        end
        @(negedge clk) pause = 1'b1;
        @(negedge clk) pause = 1'b0;
        send_move();
        checks++;
        if ({if_a.ballX, if_a.ballY} !== {10'd316, 10'd236}) begin
            errors++;
            $display("FAIL unpaused_move: x=%0d y=%0d required 316 236", if_a.ballX, if_a.ballY);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_tick();
        test_second_tick();
        test_enable_and_drop();
        test_saturation();
        test_reset_mid_move();
`ifdef BALL_PAUSE_EN
        test_pause();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
